// File: rtl/ft_cmd_pkg.sv
// Shared types and constants for the FT232H host command decoder.
package ft_cmd_pkg;

  typedef enum logic [3:0] {
    S_HUNT,
    S_OPC,
    S_ADDR,
    S_DHI,
    S_DLO,
    S_EXEC_WR,
    S_EXEC_RD,
    S_RESP0,
    S_RESP1
  } state_t;

  localparam logic [7:0] OP_WR      = 8'h01;
  localparam logic [7:0] OP_RD      = 8'h02;
  localparam logic [7:0] TAG_WR_ACK = 8'hAC;
  localparam logic [7:0] TAG_RD_ACK = 8'hAD;
  localparam logic [7:0] TAG_BAD_OP = 8'hEE;
  localparam logic [7:0] TAG_RD_TMO = 8'hEF;

  // States in which the decoder pulls bytes from the RX FIFO.
  function automatic logic is_fetch_state(input state_t s);
    return (s == S_HUNT) || (s == S_OPC) || (s == S_ADDR) ||
           (s == S_DHI)  || (s == S_DLO);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ft_cmd_decoder.sv
// Parses SYNC/opcode/addr[/data] frames from the FT232H RX FIFO, drives the
// register bus and returns ack/read-data words through the TX FIFO.
module ft_cmd_decoder
  import ft_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         RD_TIMEOUT   = 255,
  parameter int         BYTE_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        rx_rdreq,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        tx_wrreq,
  output logic [15:0] tx_data,
  input  logic        tx_full,
  output logic        reg_wr,
  output logic        reg_rd,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  input  logic [15:0] reg_rdata,
  input  logic        reg_rdvalid,
  output logic [7:0]  err_count,
  output logic        busy
);

  state_t      state_q, state_d;
  logic        rx_rdreq_q, rx_rdreq_d;
  logic        pend_q, pend_d;
  logic        is_wr_q, is_wr_d;
  logic        rd_ok_q, rd_ok_d;
  logic        reg_wr_q, reg_wr_d;
  logic        reg_rd_q, reg_rd_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] tx_data_q, tx_data_d;
  logic [7:0]  err_q, err_d;
  logic [9:0]  byte_tmr_q, byte_tmr_d;
  logic [7:0]  rd_tmr_q, rd_tmr_d;
  logic        byte_tmo, rd_tmo;

  // pend_q marks the cycle in which rx_data holds the byte requested last cycle.
  assign byte_tmo = (byte_tmr_q == 10'(BYTE_TIMEOUT - 1));
  assign rd_tmo   = (rd_tmr_q == 8'(RD_TIMEOUT - 1));
  assign tx_wrreq = ((state_q == S_RESP0) || (state_q == S_RESP1)) && !tx_full;

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    rd_ok_d    = rd_ok_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    tx_data_d  = tx_data_q;
    err_d      = err_q;
    reg_wr_d   = 1'b0;
    reg_rd_d   = 1'b0;
    pend_d     = rx_rdreq_q;
    byte_tmr_d = byte_tmr_q + 10'd1;
    rd_tmr_d   = rd_tmr_q + 8'd1;

    case (state_q)
      S_HUNT: begin
        if (pend_q && (rx_data == SYNC_BYTE)) state_d = S_OPC;
      end
      S_OPC: begin
        if (pend_q) begin
          if ((rx_data == OP_WR) || (rx_data == OP_RD)) begin
            is_wr_d = (rx_data == OP_WR);
            state_d = S_ADDR;
          end else begin
            tx_data_d = {TAG_BAD_OP, rx_data};
            rd_ok_d   = 1'b0;
            err_d     = sat_inc8(err_q);
            state_d   = S_RESP0;
          end
        end else if (byte_tmo) begin
          err_d   = sat_inc8(err_q);
          state_d = S_HUNT;
        end
      end
      S_ADDR: begin
        if (pend_q) begin
          addr_d = rx_data;
          if (is_wr_q) begin
            state_d = S_DHI;
          end else begin
            reg_rd_d = 1'b1;
            state_d  = S_EXEC_RD;
          end
        end else if (byte_tmo) begin
          err_d   = sat_inc8(err_q);
          state_d = S_HUNT;
        end
      end
      S_DHI: begin
        if (pend_q) begin
          wdata_d[15:8] = rx_data;
          state_d       = S_DLO;
        end else if (byte_tmo) begin
          err_d   = sat_inc8(err_q);
          state_d = S_HUNT;
        end
      end
      S_DLO: begin
        if (pend_q) begin
          wdata_d[7:0] = rx_data;
          reg_wr_d     = 1'b1;
          state_d      = S_EXEC_WR;
        end else if (byte_tmo) begin
          err_d   = sat_inc8(err_q);
          state_d = S_HUNT;
        end
      end
      S_EXEC_WR: begin
        tx_data_d = {TAG_WR_ACK, addr_q};
        rd_ok_d   = 1'b0;
        state_d   = S_RESP0;
      end
      S_EXEC_RD: begin
        if (reg_rdvalid) begin
          rdata_d   = reg_rdata;
          rd_ok_d   = 1'b1;
          tx_data_d = {TAG_RD_ACK, addr_q};
          state_d   = S_RESP0;
        end else if (rd_tmo) begin
          rd_ok_d   = 1'b0;
          tx_data_d = {TAG_RD_TMO, addr_q};
          err_d     = sat_inc8(err_q);
          state_d   = S_RESP0;
        end
      end
      S_RESP0: begin
        if (tx_wrreq) begin
          if (rd_ok_q) begin
            tx_data_d = rdata_q;
            state_d   = S_RESP1;
          end else begin
            state_d = S_HUNT;
          end
        end
      end
      S_RESP1: begin
        if (tx_wrreq) state_d = S_HUNT;
      end
      default: state_d = S_HUNT;
    endcase

    if ((state_d != state_q) || pend_q) byte_tmr_d = 10'd0;
    if (state_d != state_q) rd_tmr_d = 8'd0;
    // Looking at the next state keeps reads out of EXEC/RESP and ensures the
    // FIFO cannot drain before the registered request reaches it.
    rx_rdreq_d = is_fetch_state(state_d) && !rx_empty && !rx_rdreq_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_HUNT;
      rx_rdreq_q <= 1'b0;
      pend_q     <= 1'b0;
      is_wr_q    <= 1'b0;
      rd_ok_q    <= 1'b0;
      reg_wr_q   <= 1'b0;
      reg_rd_q   <= 1'b0;
      addr_q     <= 8'd0;
      wdata_q    <= 16'd0;
      rdata_q    <= 16'd0;
      tx_data_q  <= 16'd0;
      err_q      <= 8'd0;
      byte_tmr_q <= 10'd0;
      rd_tmr_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      rx_rdreq_q <= rx_rdreq_d;
      pend_q     <= pend_d;
      is_wr_q    <= is_wr_d;
      rd_ok_q    <= rd_ok_d;
      reg_wr_q   <= reg_wr_d;
      reg_rd_q   <= reg_rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
      byte_tmr_q <= byte_tmr_d;
      rd_tmr_q   <= rd_tmr_d;
    end
  end

  assign rx_rdreq  = rx_rdreq_q;
  assign tx_data   = tx_data_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign err_count = err_q;
  assign busy      = (state_q != S_HUNT);

endmodule
